// File: rtl/alu_share_arb.sv
// alu_share_arb: two requesters share one 32-bit ALU through a two-stage pipeline (operand reg, result reg)
// with round-robin grant and full backpressure. Define ALU_ARB_FUNCHK_EN to add rsp_err for illegal fun codes.
module alu_share_arb #(
  parameter int ID_W    = 1,
  parameter bit RR_INIT = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [31:0]     req0_a,
  input  logic [31:0]     req0_b,
  input  logic [5:0]      req0_fun,
  input  logic            req0_sign,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [31:0]     req1_a,
  input  logic [31:0]     req1_b,
  input  logic [5:0]      req1_fun,
  input  logic            req1_sign,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_z,
`ifdef ALU_ARB_FUNCHK_EN
  output logic            rsp_err,
`endif
  output logic [ID_W-1:0] rsp_id,
  output logic            busy
);

  localparam logic [5:0] FUN_ADD = 6'b000000;
  localparam logic [5:0] FUN_SUB = 6'b000001;
  localparam logic [5:0] FUN_AND = 6'b011000;
  localparam logic [5:0] FUN_OR  = 6'b011110;
  localparam logic [5:0] FUN_XOR = 6'b010110;
  localparam logic [5:0] FUN_NOR = 6'b010001;
  localparam logic [5:0] FUN_A   = 6'b011010;
  localparam logic [5:0] FUN_SLL = 6'b100000;
  localparam logic [5:0] FUN_SRL = 6'b100001;
  localparam logic [5:0] FUN_SRA = 6'b100011;
  localparam logic [5:0] FUN_EQ  = 6'b110011;
  localparam logic [5:0] FUN_NEQ = 6'b110001;
  localparam logic [5:0] FUN_LT  = 6'b110101;
  localparam logic [5:0] FUN_LEZ = 6'b111101;
  localparam logic [5:0] FUN_LTZ = 6'b111011;
  localparam logic [5:0] FUN_GTZ = 6'b111111;

  // Unlisted codes fall to the default and yield zero.
  function automatic logic [31:0] alu_eval(input logic [31:0] a, input logic [31:0] b,
                                           input logic [5:0] fun, input logic sign);
    logic        lt_v;
    logic        a_neg_v;
    logic        a_zero_v;
    logic [31:0] z_v;
    lt_v     = sign ? ($signed(a) < $signed(b)) : (a < b);
    a_neg_v  = sign & a[31];
    a_zero_v = (a == 32'd0);
    case (fun)
      FUN_ADD: z_v = a + b;
      FUN_SUB: z_v = a - b;
      FUN_AND: z_v = a & b;
      FUN_OR:  z_v = a | b;
      FUN_XOR: z_v = a ^ b;
      FUN_NOR: z_v = ~(a | b);
      FUN_A:   z_v = a;
      FUN_SLL: z_v = b << a[4:0];
      FUN_SRL: z_v = b >> a[4:0];
      FUN_SRA: z_v = $unsigned($signed(b) >>> a[4:0]);
      FUN_EQ:  z_v = {31'd0, (a == b)};
      FUN_NEQ: z_v = {31'd0, (a != b)};
      FUN_LT:  z_v = {31'd0, lt_v};
      FUN_LEZ: z_v = {31'd0, (a_neg_v | a_zero_v)};
      FUN_LTZ: z_v = {31'd0, a_neg_v};
      FUN_GTZ: z_v = {31'd0, (~a_neg_v & ~a_zero_v)};
      default: z_v = 32'd0;
    endcase
    return z_v;
  endfunction

`ifdef ALU_ARB_FUNCHK_EN
  function automatic logic fun_legal(input logic [5:0] fun);
    logic ok_v;
    case (fun)
      FUN_ADD, FUN_SUB, FUN_AND, FUN_OR, FUN_XOR, FUN_NOR, FUN_A, FUN_SLL,
      FUN_SRL, FUN_SRA, FUN_EQ, FUN_NEQ, FUN_LT, FUN_LEZ, FUN_LTZ, FUN_GTZ: ok_v = 1'b1;
      default: ok_v = 1'b0;
    endcase
    return ok_v;
  endfunction
`endif

  logic            s1_v_r;
  logic [31:0]     s1_a_r;
  logic [31:0]     s1_b_r;
  logic [5:0]      s1_fun_r;
  logic            s1_sign_r;
  logic [ID_W-1:0] s1_id_r;
  logic            s2_v_r;
  logic [31:0]     rsp_z_r;
  logic [ID_W-1:0] rsp_id_r;
  logic            prio_r;
`ifdef ALU_ARB_FUNCHK_EN
  logic            rsp_err_r;
`endif

  logic            grant0_s;
  logic            grant1_s;
  logic            s2_load_s;
  logic            s1_open_s;
  logic            accept0_s;
  logic            accept1_s;
  logic            accept_s;
  logic [31:0]     sel_a_s;
  logic [31:0]     sel_b_s;
  logic [5:0]      sel_fun_s;
  logic            sel_sign_s;
  logic [31:0]     alu_z_s;

  assign s2_load_s = s1_v_r & (~s2_v_r | rsp_ready);
  assign s1_open_s = ~s1_v_r | s2_load_s;

  // Round-robin grant: prio_r names the requester that wins a tie.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0_s = ~prio_r;
      grant1_s = prio_r;
    end else begin
      grant0_s = req0_valid;
      grant1_s = req1_valid;
    end
  end

  assign req0_ready = grant0_s & s1_open_s;
  assign req1_ready = grant1_s & s1_open_s;
  assign accept0_s  = req0_valid & req0_ready;
  assign accept1_s  = req1_valid & req1_ready;
  assign accept_s   = accept0_s | accept1_s;

  // Operand select for the accepted requester.
  always_comb begin
    sel_a_s    = req0_a;
    sel_b_s    = req0_b;
    sel_fun_s  = req0_fun;
    sel_sign_s = req0_sign;
    if (accept1_s) begin
      sel_a_s    = req1_a;
      sel_b_s    = req1_b;
      sel_fun_s  = req1_fun;
      sel_sign_s = req1_sign;
    end else begin
      sel_a_s    = req0_a;
      sel_b_s    = req0_b;
      sel_fun_s  = req0_fun;
      sel_sign_s = req0_sign;
    end
  end

  assign alu_z_s = alu_eval(s1_a_r, s1_b_r, s1_fun_r, s1_sign_r);

  // Stage 1 operand register and round-robin priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v_r    <= 1'b0;
      s1_a_r    <= 32'd0;
      s1_b_r    <= 32'd0;
      s1_fun_r  <= 6'd0;
      s1_sign_r <= 1'b0;
      s1_id_r   <= ID_W'(1'b0);
      prio_r    <= RR_INIT;
    end else if (accept_s) begin
      s1_v_r    <= 1'b1;
      s1_a_r    <= sel_a_s;
      s1_b_r    <= sel_b_s;
      s1_fun_r  <= sel_fun_s;
      s1_sign_r <= sel_sign_s;
      s1_id_r   <= ID_W'(accept1_s);
      prio_r    <= ~accept1_s;
    end else if (s2_load_s) begin
      s1_v_r <= 1'b0;
    end
  end

  // Stage 2 result register; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_v_r    <= 1'b0;
      rsp_z_r   <= 32'd0;
      rsp_id_r  <= ID_W'(1'b0);
`ifdef ALU_ARB_FUNCHK_EN
      rsp_err_r <= 1'b0;
`endif
    end else if (s2_load_s) begin
      s2_v_r    <= 1'b1;
      rsp_z_r   <= alu_z_s;
      rsp_id_r  <= s1_id_r;
`ifdef ALU_ARB_FUNCHK_EN
      rsp_err_r <= ~fun_legal(s1_fun_r);
`endif
    end else if (rsp_ready) begin
      s2_v_r <= 1'b0;
    end
  end

  assign rsp_valid = s2_v_r;
  assign rsp_z     = rsp_z_r;
  assign rsp_id    = rsp_id_r;
  assign busy      = s1_v_r | s2_v_r;
`ifdef ALU_ARB_FUNCHK_EN
  assign rsp_err   = rsp_err_r;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed scenarios plus randomized traffic checked against a queue-based
// model of the shared-ALU pipeline. Inputs change at negedge; outputs are sampled 1 time unit later.
module tb_alu_share_arb;

  localparam bit RR_INIT = 1'b0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
  logic [5:0]  req0_fun = 6'd0, req1_fun = 6'd0;
  logic        req0_sign = 1'b0, req1_sign = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_z;
  logic [0:0]  rsp_id;
  logic        busy;
`ifdef ALU_ARB_FUNCHK_EN
  logic        rsp_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.ID_W(1), .RR_INIT(RR_INIT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_fun(req0_fun), .req0_sign(req0_sign),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_fun(req1_fun), .req1_sign(req1_sign),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_z(rsp_z),
`ifdef ALU_ARB_FUNCHK_EN
    .rsp_err(rsp_err),
`endif
    .rsp_id(rsp_id), .busy(busy)
  );

  localparam logic [5:0] LEGAL [16] = '{6'b000000, 6'b000001, 6'b011000, 6'b011110,
                                        6'b010110, 6'b010001, 6'b011010, 6'b100000,
                                        6'b100001, 6'b100011, 6'b110011, 6'b110001,
                                        6'b110101, 6'b111101, 6'b111011, 6'b111111};

  // In-flight ops in issue order; vis marks the op sitting in the result register.
  typedef struct { logic [31:0] z; bit id; bit err; bit vis; } op_t;
  op_t q[$];
  bit  m_prio = RR_INIT;

  function automatic bit is_legal(logic [5:0] fun);
    for (int i = 0; i < 16; i++) if (LEGAL[i] == fun) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_alu(logic [31:0] a, logic [31:0] b, logic [5:0] fun, bit sgn);
    longint av = sgn ? longint'($signed(a)) : longint'(a);
    longint bv = sgn ? longint'($signed(b)) : longint'(b);
    longint bs = longint'($signed(b));
    case (fun)
      6'b000000: return a + b;
      6'b000001: return a - b;
      6'b011000: return a & b;
      6'b011110: return a | b;
      6'b010110: return a ^ b;
      6'b010001: return ~(a | b);
      6'b011010: return a;
      6'b100000: return b << a[4:0];
      6'b100001: return b >> a[4:0];
      6'b100011: return 32'(bs >>> a[4:0]);
      6'b110011: return 32'(a == b);
      6'b110001: return 32'(a != b);
      6'b110101: return 32'(av < bv);
      6'b111101: return 32'(av <= 0);
      6'b111011: return 32'(av < 0);
      6'b111111: return 32'(av > 0);
      default:   return 32'd0;
    endcase
  endfunction

  task automatic exp_now(output bit r0, output bit r1, output bit rv, output logic [31:0] z,
                         output bit id, output bit er, output bit bz);
    bit drain, open;
    drain = (q.size() > 0) && q[0].vis && rsp_ready;
    open  = (q.size() < 2) || drain;
    r0 = req0_valid && (!req1_valid || !m_prio) && open;
    r1 = req1_valid && (!req0_valid ||  m_prio) && open;
    rv = (q.size() > 0) && q[0].vis;
    z  = rv ? q[0].z : 32'd0;
    id = rv ? q[0].id : 1'b0;
    er = rv ? q[0].err : 1'b0;
    bz = (q.size() > 0);
  endtask

  task automatic model_clock();
    bit r0, r1, rv, id, er, bz;
    logic [31:0] z;
    op_t o;
    if (reset) begin
      q.delete();
      m_prio = RR_INIT;
      return;
    end
    exp_now(r0, r1, rv, z, id, er, bz);
    if (rv && rsp_ready) void'(q.pop_front());
    if (q.size() > 0 && !q[0].vis) q[0].vis = 1'b1;
    if (r0 || r1) begin
      o.z   = r1 ? ref_alu(req1_a, req1_b, req1_fun, req1_sign) : ref_alu(req0_a, req0_b, req0_fun, req0_sign);
      o.err = r1 ? !is_legal(req1_fun) : !is_legal(req0_fun);
      o.id  = r1;
      o.vis = 1'b0;
      q.push_back(o);
      m_prio = !r1;
    end
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_tests++; if (rsp_z !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_z got %h exp 0", rsp_z); end
    n_tests++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_id got %b exp 0", rsp_id); end
    n_tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b%b exp 00", req0_ready, req1_ready); end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_tests++; if (req0_ready !== !RR_INIT || req1_ready !== RR_INIT) begin
      n_fail++; $display("FAIL reset_prio got r0=%b r1=%b exp r0=%b", req0_ready, req1_ready, !RR_INIT); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_single();
    req0_a = 32'd5; req0_b = 32'd7; req0_fun = 6'b000000; req0_sign = 1'b0; req0_valid = 1'b1;
    rsp_ready = 1'b1;
    #1;
    n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got %b exp 1", req0_ready); end
    tick();
    req0_valid = 1'b0;
    #1;
    n_tests++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_t1 got v=%b busy=%b exp v=0 busy=1", rsp_valid, busy); end
    tick();
    #1;
    n_tests++; if (rsp_valid !== 1'b1 || rsp_z !== 32'd12 || rsp_id !== 1'b0) begin
      n_fail++; $display("FAIL single_rsp got v=%b z=%h id=%b exp v=1 z=c id=0", rsp_valid, rsp_z, rsp_id); end
    tick();
    #1;
    n_tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_drain got v=%b busy=%b exp 0 0", rsp_valid, busy); end
  endtask

  task automatic test_contention();
    logic [31:0] exp_z;
    reset = 1'b1; tick(); reset = 1'b0;
    rsp_ready = 1'b1;
    req0_a = 32'd10; req0_b = 32'd3; req0_fun = 6'b000001; req0_sign = 1'b0;
    req1_a = 32'd4; req1_b = 32'h8000_0000; req1_fun = 6'b100011; req1_sign = 1'b0;
    for (int c = 0; c < 8; c++) begin
      req0_valid = (c < 4); req1_valid = (c < 4);
      #1;
      if (c < 4) begin
        n_tests++; if (req0_ready !== (c % 2 == 0) || req1_ready !== (c % 2 == 1)) begin
          n_fail++; $display("FAIL contention_grant c=%0d got %b%b", c, req0_ready, req1_ready); end
      end
      if (c >= 2 && c < 6) begin
        exp_z = ((c - 2) % 2 == 1) ? 32'hF800_0000 : 32'd7;
        n_tests++; if (rsp_valid !== 1'b1 || rsp_z !== exp_z || rsp_id !== 1'((c - 2) % 2)) begin
          n_fail++; $display("FAIL contention_rsp c=%0d got v=%b z=%h id=%b exp z=%h", c, rsp_valid, rsp_z, rsp_id, exp_z); end
      end
      if (c >= 6) begin
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL contention_idle c=%0d got v=%b exp 0", c, rsp_valid); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b1; req1_valid = 1'b0;
    req0_a = 32'd1; req0_b = 32'd2; req0_fun = 6'b000000; req0_valid = 1'b1;
    #1;
    n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept_a got %b exp 1", req0_ready); end
    tick();
    req0_valid = 1'b0;
    req1_a = 32'hF0; req1_b = 32'h0F; req1_fun = 6'b010110; req1_sign = 1'b0; req1_valid = 1'b1;
    #1;
    n_tests++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept_b got %b exp 1", req1_ready); end
    tick();
    req1_valid = 1'b0;
    req0_a = 32'h100; req0_b = 32'h1; req0_fun = 6'b011110; req0_valid = 1'b1;
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++; if (rsp_valid !== 1'b1 || rsp_z !== 32'd3 || rsp_id !== 1'b0 || req0_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++; $display("FAIL bp_stall c=%0d got v=%b z=%h id=%b r0=%b busy=%b", c, rsp_valid, rsp_z, rsp_id, req0_ready, busy); end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    n_tests++; if (rsp_valid !== 1'b1 || rsp_z !== 32'd3 || req0_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release got v=%b z=%h r0=%b exp 1 3 1", rsp_valid, rsp_z, req0_ready); end
    tick();
    req0_valid = 1'b0;
    #1;
    n_tests++; if (rsp_valid !== 1'b1 || rsp_z !== 32'hFF || rsp_id !== 1'b1) begin
      n_fail++; $display("FAIL bp_second got v=%b z=%h id=%b exp 1 ff 1", rsp_valid, rsp_z, rsp_id); end
    tick();
    #1;
    n_tests++; if (rsp_valid !== 1'b1 || rsp_z !== 32'h101 || rsp_id !== 1'b0) begin
      n_fail++; $display("FAIL bp_third got v=%b z=%h id=%b exp 1 101 0", rsp_valid, rsp_z, rsp_id); end
    tick();
    #1;
    n_tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_empty got v=%b busy=%b exp 0 0", rsp_valid, busy); end
  endtask

  task automatic test_compare();
    rsp_ready = 1'b1; req1_valid = 1'b0;
    req0_a = 32'hFFFF_FFFF; req0_b = 32'd1; req0_fun = 6'b110101; req0_sign = 1'b1; req0_valid = 1'b1;
    tick();
    req0_sign = 1'b0;
    tick();
    req0_valid = 1'b0;
    #1;
    n_tests++; if (rsp_valid !== 1'b1 || rsp_z !== 32'd1) begin n_fail++; $display("FAIL lt_signed got v=%b z=%h exp 1 1", rsp_valid, rsp_z); end
    tick();
    #1;
    n_tests++; if (rsp_valid !== 1'b1 || rsp_z !== 32'd0) begin n_fail++; $display("FAIL lt_unsigned got v=%b z=%h exp 1 0", rsp_valid, rsp_z); end
    tick();
  endtask

  task automatic test_reset_midflight();
    rsp_ready = 1'b0;
    req0_a = 32'd1; req0_b = 32'd1; req0_fun = 6'b000000; req0_valid = 1'b1; req1_valid = 1'b0;
    tick();
    req0_valid = 1'b0;
    req1_a = 32'd2; req1_b = 32'd2; req1_fun = 6'b000000; req1_valid = 1'b1;
    #1;
    n_tests++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL rmf_fill got %b exp 1", req1_ready); end
    tick();
    req1_valid = 1'b0;
    #1;
    n_tests++; if (busy !== 1'b1 || rsp_valid !== 1'b1 || req0_ready !== 1'b0) begin
      n_fail++; $display("FAIL rmf_full got busy=%b v=%b", busy, rsp_valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0; rsp_ready = 1'b1;
    #1;
    n_tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmf_cleared got v=%b busy=%b exp 0 0", rsp_valid, busy); end
    req0_a = 32'd20; req0_b = 32'd22; req0_fun = 6'b000000; req0_valid = 1'b1;
    req1_a = 32'd9;  req1_b = 32'd9;  req1_fun = 6'b000000; req1_valid = 1'b1;
    #1;
    n_tests++; if (req0_ready !== !RR_INIT || req1_ready !== RR_INIT) begin
      n_fail++; $display("FAIL rmf_prio got %b%b", req0_ready, req1_ready); end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    #1;
    n_tests++; if (rsp_valid !== 1'b1 || rsp_z !== 32'd42 || rsp_id !== 1'b0) begin
      n_fail++; $display("FAIL rmf_after got v=%b z=%h id=%b exp 1 2a 0", rsp_valid, rsp_z, rsp_id); end
    tick(); tick();
    #1;
    n_tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmf_drain got v=%b busy=%b exp 0 0", rsp_valid, busy); end
  endtask

`ifdef ALU_ARB_FUNCHK_EN
  task automatic test_funchk();
    rsp_ready = 1'b1; req1_valid = 1'b0;
    req0_a = 32'd5; req0_b = 32'd7; req0_fun = 6'b111000; req0_valid = 1'b1;
    tick();
    req0_a = 32'hF0; req0_b = 32'h0F; req0_fun = 6'b011110;
    tick();
    req0_valid = 1'b0;
    #1;
    n_tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_z !== 32'd0) begin
      n_fail++; $display("FAIL funchk_illegal got v=%b err=%b z=%h exp 1 1 0", rsp_valid, rsp_err, rsp_z); end
    tick();
    #1;
    n_tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_z !== 32'hFF) begin
      n_fail++; $display("FAIL funchk_legal got v=%b err=%b z=%h exp 1 0 ff", rsp_valid, rsp_err, rsp_z); end
    tick();
  endtask
`endif

  // Random traffic; a requester keeps its op while valid and not yet accepted.
  task automatic test_random();
    bit r0, r1, rv, id, er, bz;
    bit hold0 = 1'b0, hold1 = 1'b0;
    logic [31:0] z;
    for (int i = 0; i < 500; i++) begin
      if (!hold0) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
        req0_b = $urandom();
        req0_fun = ($urandom_range(0, 7) == 0) ? 6'($urandom()) : LEGAL[$urandom_range(0, 15)];
        req0_sign = 1'($urandom());
      end
      if (!hold1) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
        req1_b = ($urandom_range(0, 3) == 0) ? req1_a : $urandom();
        req1_fun = ($urandom_range(0, 7) == 0) ? 6'($urandom()) : LEGAL[$urandom_range(0, 15)];
        req1_sign = 1'($urandom());
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_now(r0, r1, rv, z, id, er, bz);
      n_tests++; if (req0_ready !== r0 || req1_ready !== r1) begin
        n_fail++; $display("FAIL rnd_ready i=%0d got %b%b exp %b%b", i, req0_ready, req1_ready, r0, r1); end
      n_tests++; if (rsp_valid !== rv || busy !== bz) begin
        n_fail++; $display("FAIL rnd_valid i=%0d got v=%b busy=%b exp v=%b busy=%b", i, rsp_valid, busy, rv, bz); end
      if (rv) begin
        n_tests++; if (rsp_z !== z || rsp_id !== id) begin
          n_fail++; $display("FAIL rnd_rsp i=%0d got z=%h id=%b exp z=%h id=%b", i, rsp_z, rsp_id, z, id); end
`ifdef ALU_ARB_FUNCHK_EN
        n_tests++; if (rsp_err !== er) begin n_fail++; $display("FAIL rnd_err i=%0d got %b exp %b", i, rsp_err, er); end
`endif
      end
      hold0 = req0_valid && !r0;
      hold1 = req1_valid && !r1;
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    tick(); tick(); tick();
    #1;
    n_tests++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_drain got busy=%b v=%b exp 0 0", busy, rsp_valid); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_compare();
    test_reset_midflight();
`ifdef ALU_ARB_FUNCHK_EN
    test_funchk();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
